// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command issuer for the registered 4-bit ALU.
// Results return on a valid/ready response stream. Only one command is at the ALU at a time.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic             alu_en,
  output logic [2:0]       alu_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [2:0]       rsp_op,
  output logic             busy,
  output logic [CNT_W-1:0] cmd_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t r_state, w_next;
  logic [10:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_empty, w_full, w_push, w_pop, w_cap, w_hs;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty   = r_wr == r_rd;
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push    = cmd_valid && !w_full;
  assign cmd_ready = !w_full;
  assign busy      = r_state != IDLE || !w_empty;
  always_comb begin
    w_hs   = r_state == RESP && rsp_ready;
    w_cap  = r_state == CAPTURE;
    w_pop  = !w_empty && (r_state == IDLE || w_hs);
    w_next = w_pop ? ISSUE : r_state == ISSUE ? CAPTURE : w_cap ? RESP :
             (r_state == RESP && !w_hs) ? RESP : IDLE;
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= IDLE;
      r_wr       <= '0;
      r_rd       <= '0;
      alu_en     <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_op     <= '0;
      cmd_count  <= '0;
    end else begin
      r_state <= w_next;
      alu_en  <= w_pop;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
        {alu_op, alu_a, alu_b} <= r_mem[r_rd[AW-1:0]];
      end
      if (w_cap) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zero   <= alu_zero;
        rsp_op     <= alu_op;
      end else if (w_hs) rsp_valid <= 1'b0;
      if (w_hs) cmd_count <= cmd_count + 1'b1;
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed stimulus with a registered ALU, a transaction-level
// scoreboard checked every cycle, and hand-computed spot checks.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;
  logic clk, rst, cmd_valid, cmd_ready, alu_en, rsp_valid, rsp_ready, rsp_carry, rsp_zero, busy;
  logic [2:0] cmd_op, alu_op, rsp_op;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b, rsp_result;
  logic [7:0] cmd_count;
  logic [3:0] alu_result = 4'd0;
  logic alu_carry = 1'b0, alu_zero = 1'b0;
  int n_vec = 0, n_err = 0;
  alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_op(rsp_op),
    .busy(busy), .cmd_count(cmd_count)
  );
  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin #100000; $display("FAIL watchdog: got timeout expected finish"); $fatal(1); end
  // Returns {carry, zero, result}; carry is the borrow bit for sub and dec.
  function automatic logic [5:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {1'b0, a} + 5'd1;
      default: r = {1'b0, a} - 5'd1;
    endcase
    return {r[4], r[3:0] == 4'd0, r[3:0]};
  endfunction
  always @(posedge clk) if (alu_en) {alu_carry, alu_zero, alu_result} <= alu_fn(alu_op, alu_a, alu_b);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Model: queue of pending commands plus the phase of the one in flight
  // (0 none, 1 enable cycle, 2 ALU computing, 3 response presented).
  logic [10:0] m_q[$];
  logic [10:0] m_cur = '0;
  int m_ph = 0;
  logic [7:0] m_cnt = '0;
  initial begin
    bit hs, acc, pp;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete(); m_ph = 0; m_cnt = '0;
      end else begin
        hs  = m_ph == 3 && rsp_ready;
        acc = cmd_valid && m_q.size() < DEPTH;
        pp  = (m_ph == 0 || hs) && m_q.size() > 0;
        if (pp) m_cur = m_q.pop_front();
        if (acc) m_q.push_back({cmd_op, cmd_a, cmd_b});
        m_ph = pp ? 1 : m_ph == 1 ? 2 : m_ph == 2 ? 3 : (m_ph == 3 && !hs) ? 3 : 0;
        if (hs) m_cnt = m_cnt + 8'd1;
      end
    end
  end
  logic [5:0] m_e;
  always @(negedge clk) if (!rst) begin
    chk("cmd_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
    chk("busy", 32'(busy), 32'(m_ph != 0 || m_q.size() != 0));
    chk("alu_en", 32'(alu_en), 32'(m_ph == 1));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 3));
    chk("cmd_count", 32'(cmd_count), 32'(m_cnt));
    if (m_ph != 0) chk("alu_cmd", {21'd0, alu_op, alu_a, alu_b}, {21'd0, m_cur});
    if (m_ph == 3) begin
      m_e = alu_fn(m_cur[10:8], m_cur[7:4], m_cur[3:0]);
      chk("rsp_data", {26'd0, rsp_carry, rsp_zero, rsp_result}, {26'd0, m_e});
      chk("rsp_op", 32'(rsp_op), 32'(m_cur[10:8]));
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic run_one(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] res, input logic c, input logic z, input logic [7:0] cnt);
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    step();
    cmd_valid = 0;
    step();
    chk("lat_en", 32'(alu_en), 1); chk("lat_a", 32'(alu_a), 32'(a));
    step();
    chk("en_one_cycle", 32'(alu_en), 0); chk("early_valid", 32'(rsp_valid), 0);
    step();
    chk("lat_valid", 32'(rsp_valid), 1); chk("res", 32'(rsp_result), 32'(res));
    chk("carry", 32'(rsp_carry), 32'(c)); chk("zero", 32'(rsp_zero), 32'(z));
    chk("op_echo", 32'(rsp_op), 32'(op));
    step();
    chk("count", 32'(cmd_count), 32'(cnt)); chk("busy_done", 32'(busy), 0);
  endtask
  initial begin
    int nresp, nacc, n;
    int t[5];
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 1;
    chk("fn_add", 32'(alu_fn(3'd0, 4'd9, 4'd8)), 32'h21);
    chk("fn_sub", 32'(alu_fn(3'd1, 4'd3, 4'd3)), 32'h10);
    chk("fn_dec", 32'(alu_fn(3'd7, 4'd0, 4'd0)), 32'h2f);
    repeat (2) @(posedge clk); #1;
    chk("rst_en", 32'(alu_en), 0); chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_count", 32'(cmd_count), 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    rst = 0;
    step();
    run_one(3'd0, 4'd9, 4'd8, 4'h1, 1, 0, 8'd1);
    run_one(3'd1, 4'd3, 4'd3, 4'h0, 0, 1, 8'd2);
    run_one(3'd7, 4'd0, 4'd0, 4'hf, 1, 0, 8'd3);
    // Backpressure: DEPTH+1 commands accepted, then a long stall in RESP.
    rsp_ready = 0; cmd_valid = 1;
    for (int i = 0; i < 6; i++) begin
      cmd_op = 3'(i); cmd_a = 4'(3 * i + 1); cmd_b = 4'd5;
      if (i == 4) chk("ready_before_full", 32'(cmd_ready), 1);
      if (i == 5) chk("full_ready", 32'(cmd_ready), 0);
      step();
    end
    cmd_valid = 0;
    for (int k = 0; k < 10; k++) begin
      chk("hold_valid", 32'(rsp_valid), 1); chk("hold_res", 32'(rsp_result), 6);
      chk("hold_en", 32'(alu_en), 0); chk("hold_nopop", 32'(cmd_ready), 0);
      step();
    end
    rsp_ready = 1; nresp = 0;
    for (int k = 0; k < 40 && nresp < 5; k++) begin
      if (rsp_valid) begin
        if (nresp == 4) chk("last_res", 32'(rsp_result), 8);
        t[nresp] = k; nresp++;
      end
      step();
    end
    chk("n_resp", 32'(nresp), 5);
    for (int j = 1; j < 5; j++) chk("spacing", 32'(t[j] - t[j-1]), 3);
    chk("bp_count", 32'(cmd_count), 8); chk("bp_busy", 32'(busy), 0);
    // Simultaneous push and pop with two entries queued.
    rsp_ready = 0; cmd_valid = 1;
    for (int i = 0; i < 3; i++) begin cmd_op = 3'd2; cmd_a = 4'(i + 7); cmd_b = 4'hc; step(); end
    cmd_valid = 0;
    for (int k = 0; k < 10 && !rsp_valid; k++) step();
    chk("pp_wait", 32'(rsp_valid), 1);
    rsp_ready = 1; cmd_valid = 1; cmd_op = 3'd3; cmd_a = 4'h1; cmd_b = 4'h2;
    chk("pp_ready", 32'(cmd_ready), 1);
    step();
    rsp_ready = 0; nacc = 0;
    for (int k = 0; k < 6; k++) begin
      cmd_op = 3'd4; cmd_a = 4'(k); cmd_b = 4'h9;
      if (cmd_ready) nacc++;
      step();
    end
    cmd_valid = 0;
    chk("pp_room", 32'(nacc), 2);
    rsp_ready = 1;
    for (int k = 0; k < 60 && busy; k++) step();
    chk("pp_busy", 32'(busy), 0); chk("pp_count", 32'(cmd_count), 14);
    // Async reset during ISSUE with two commands still queued.
    rsp_ready = 0; cmd_valid = 1;
    cmd_op = 3'd0; cmd_a = 4'd2; cmd_b = 4'd3; step();
    cmd_op = 3'd3; cmd_a = 4'd6; cmd_b = 4'd9; step();
    cmd_op = 3'd4; cmd_a = 4'd1; cmd_b = 4'd1; step();
    cmd_op = 3'd5; cmd_a = 4'd2; cmd_b = 4'd2; step();
    cmd_valid = 0;
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    rsp_ready = 1; step(); rsp_ready = 0;
    chk("pre_rst_en", 32'(alu_en), 1);
    #2 rst = 1;
    #1;
    chk("arst_en", 32'(alu_en), 0);
    chk("arst_cmd", {21'd0, alu_op, alu_a, alu_b}, 0);
    chk("arst_valid", 32'(rsp_valid), 0);
    chk("arst_rsp", {24'd0, rsp_op, rsp_carry, rsp_zero, rsp_result}, 0);
    chk("arst_count", 32'(cmd_count), 0);
    chk("arst_busy", 32'(busy), 0); chk("arst_ready", 32'(cmd_ready), 1);
    #3 rst = 0;
    rsp_ready = 1;
    for (int k = 0; k < 12; k++) begin step(); chk("no_stale", 32'(rsp_valid | alu_en), 0); end
    chk("post_rst_count", 32'(cmd_count), 0);
    // 256 completions wrap the 8-bit counter back to zero.
    n = 0; cmd_valid = 1;
    for (int k = 0; k < 2000 && n < 256; k++) begin
      cmd_op = 3'(n); cmd_a = 4'(n); cmd_b = 4'(n >> 4);
      if (cmd_ready) n++;
      step();
    end
    cmd_valid = 0;
    chk("wrap_sent", 32'(n), 256);
    for (int k = 0; k < 100 && busy; k++) step();
    chk("wrap_busy", 32'(busy), 0); chk("wrap_count", 32'(cmd_count), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
